// File: rtl/lfm_pulse_capture_pkg.sv
// Shared types for the LFM pulse capture block: widths, framing FSM states and FIFO entry layout.
package lfm_pkg;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {IDLE, CAPTURE, CLOSE} state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/lfm_pulse_capture_if.sv
// Sample-in / packet-out bundle of the pulse capture block plus its status outputs.
interface lfm_pulse_capture_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 32
);
  logic              IN_VALID;
  logic [DATA_W-1:0] IN_DATA;
  logic [CNT_W-1:0]  EXPECTED_SAMPLES;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_LAST;
  logic              PULSE_DONE;
  logic [CNT_W-1:0]  SAMPLE_COUNT;
  logic              COUNT_ERR;
  logic              OVERFLOW;

  modport master (
    output IN_VALID, IN_DATA, EXPECTED_SAMPLES, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_LAST, PULSE_DONE, SAMPLE_COUNT, COUNT_ERR, OVERFLOW
  );

  modport slave (
    input  IN_VALID, IN_DATA, EXPECTED_SAMPLES, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_LAST, PULSE_DONE, SAMPLE_COUNT, COUNT_ERR, OVERFLOW
  );
endinterface

// File: rtl/lfm_pulse_capture_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is honoured only alongside a pop.
module lfm_sync_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 64
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/lfm_pulse_capture.sv
// Frames runs of valid samples into pulses, tags the last sample via a one-entry hold register,
// buffers them in a FWFT FIFO and checks each pulse length against the expected sample count.
module lfm_pulse_capture #(
  parameter int DATA_W = lfm_pkg::DATA_W,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = lfm_pkg::CNT_W
) (
  input logic                CLK,
  input logic                RESET,
  lfm_pulse_capture_if.slave bus
);
  import lfm_pkg::*;

  state_e            state;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  cnt;
  logic              pulse_done, count_err, overflow;
  logic [CNT_W-1:0]  sample_count;

  fifo_entry_t       push_entry, head;
  logic              push, pop, full, empty;

  // The held sample leaves on the next accepted sample, or tagged last in CLOSE.
  assign push            = ((state == CAPTURE) && bus.IN_VALID) || (state == CLOSE);
  assign push_entry.last = (state == CLOSE);
  assign push_entry.data = hold_data;
  assign pop             = bus.OUT_VALID && bus.OUT_READY;

  lfm_sync_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.OUT_VALID    = !empty;
  assign bus.OUT_DATA     = head.data;
  assign bus.OUT_LAST     = head.last;
  assign bus.PULSE_DONE   = pulse_done;
  assign bus.SAMPLE_COUNT = sample_count;
  assign bus.COUNT_ERR    = count_err;
  assign bus.OVERFLOW     = overflow;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      hold_data    <= '0;
      cnt          <= '0;
      pulse_done   <= 1'b0;
      sample_count <= '0;
      count_err    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      pulse_done <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.IN_VALID) begin
            hold_data <= bus.IN_DATA;
            cnt       <= CNT_W'(1);
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.IN_VALID) begin
            hold_data <= bus.IN_DATA;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end else begin
            // Pulse status is published on entry to CLOSE, independent of whether the last entry fits.
            state        <= CLOSE;
            pulse_done   <= 1'b1;
            sample_count <= cnt;
            if (cnt != bus.EXPECTED_SAMPLES) count_err <= 1'b1;
          end
        end
        CLOSE: begin
          if (bus.IN_VALID) begin
            hold_data <= bus.IN_DATA;
            cnt       <= CNT_W'(1);
            state     <= CAPTURE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfm_pulse_capture.sv
// Directed bench for lfm_pulse_capture: framing, back-to-back pulses, overflow, backpressure, reset.
module tb_lfm_pulse_capture;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  lfm_pulse_capture_if #(.DATA_W(12), .CNT_W(32)) bus ();

  lfm_pulse_capture #(.DATA_W(12), .DEPTH(64), .CNT_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] out_q [$];
  int          pd_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_data = '0;

  // Output monitor: records accepted entries {last,data}, counts PULSE_DONE cycles, checks stall stability.
  always @(negedge CLK) begin
    if (!RESET) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.OUT_VALID && bus.OUT_READY) out_q.push_back({bus.OUT_LAST, bus.OUT_DATA});
      if (bus.PULSE_DONE) pd_cnt++;
      if (prev_stall && bus.OUT_VALID && (bus.OUT_DATA !== prev_data)) stall_viol++;
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      prev_data  = bus.OUT_DATA;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    pd_cnt = 0;
    stall_viol = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    clear_mon();
  endtask

  task automatic send_pulse(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 12'(start + i);
    end
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = '0;
    bus.OUT_READY = 1'b0;
    bus.EXPECTED_SAMPLES = '0;
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests += 7;
    if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset OUT_VALID got %b want 0", bus.OUT_VALID); end
    if (bus.OUT_DATA !== 12'h0) begin n_fail++; $display("FAIL reset OUT_DATA got %h want 0", bus.OUT_DATA); end
    if (bus.OUT_LAST !== 1'b0) begin n_fail++; $display("FAIL reset OUT_LAST got %b want 0", bus.OUT_LAST); end
    if (bus.PULSE_DONE !== 1'b0) begin n_fail++; $display("FAIL reset PULSE_DONE got %b want 0", bus.PULSE_DONE); end
    if (bus.SAMPLE_COUNT !== 32'd0) begin n_fail++; $display("FAIL reset SAMPLE_COUNT got %0d want 0", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL reset COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    if (bus.OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset OVERFLOW got %b want 0", bus.OVERFLOW); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    clear_mon();
  endtask

  task automatic test_single_pulse();
    bus.OUT_READY = 1'b1;
    bus.EXPECTED_SAMPLES = 32'd10;
    clear_mon();
    send_pulse(10, 1);
    // Fall seen at the next edge; PULSE_DONE occupies exactly the following cycle.
    @(negedge CLK);
    n_tests++;
    if (bus.PULSE_DONE !== 1'b0) begin n_fail++; $display("FAIL single pd_before got %b want 0", bus.PULSE_DONE); end
    @(negedge CLK);
    n_tests += 2;
    if (bus.PULSE_DONE !== 1'b1) begin n_fail++; $display("FAIL single pd_cycle got %b want 1", bus.PULSE_DONE); end
    if (bus.SAMPLE_COUNT !== 32'd10) begin n_fail++; $display("FAIL single count_at_done got %0d want 10", bus.SAMPLE_COUNT); end
    @(negedge CLK);
    n_tests++;
    if (bus.PULSE_DONE !== 1'b0) begin n_fail++; $display("FAIL single pd_after got %b want 0", bus.PULSE_DONE); end
    repeat (5) @(negedge CLK);
    n_tests += 3;
    if (out_q.size() != 10) begin n_fail++; $display("FAIL single n_entries got %0d want 10", out_q.size()); end
    if (pd_cnt != 1) begin n_fail++; $display("FAIL single pd_cnt got %0d want 1", pd_cnt); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL single COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 9), 12'(i + 1)}) begin
        n_fail++; $display("FAIL single entry%0d got %h want %h", i, out_q[i], {(i == 9), 12'(i + 1)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_q [$];
    bus.OUT_READY = 1'b1;
    bus.EXPECTED_SAMPLES = 32'd5;
    clear_mon();
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 12'(16'h010 + i)});
    for (int i = 0; i < 7; i++) exp_q.push_back({(i == 6), 12'(16'h020 + i)});
    send_pulse(5, 'h010);
    send_pulse(7, 'h020);
    repeat (6) @(negedge CLK);
    n_tests += 4;
    if (out_q.size() != 12) begin n_fail++; $display("FAIL b2b n_entries got %0d want 12", out_q.size()); end
    if (pd_cnt != 2) begin n_fail++; $display("FAIL b2b pd_cnt got %0d want 2", pd_cnt); end
    if (bus.SAMPLE_COUNT !== 32'd7) begin n_fail++; $display("FAIL b2b SAMPLE_COUNT got %0d want 7", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b1) begin n_fail++; $display("FAIL b2b COUNT_ERR got %b want 1", bus.COUNT_ERR); end
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b entry%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.OUT_READY = 1'b0;
    bus.EXPECTED_SAMPLES = 32'd70;
    send_pulse(70, 1);
    repeat (4) @(negedge CLK);
    n_tests += 4;
    if (bus.OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf OVERFLOW got %b want 1", bus.OVERFLOW); end
    if (bus.SAMPLE_COUNT !== 32'd70) begin n_fail++; $display("FAIL ovf SAMPLE_COUNT got %0d want 70", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL ovf COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    if (pd_cnt != 1) begin n_fail++; $display("FAIL ovf pd_cnt got %0d want 1", pd_cnt); end
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b1;
    repeat (80) @(negedge CLK);
    n_tests += 2;
    if (out_q.size() != 64) begin n_fail++; $display("FAIL ovf n_entries got %0d want 64", out_q.size()); end
    if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf drained OUT_VALID got %b want 0", bus.OUT_VALID); end
    for (int i = 0; i < 64 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {1'b0, 12'(i + 1)}) begin n_fail++; $display("FAIL ovf entry%0d got %h want %h", i, out_q[i], {1'b0, 12'(i + 1)}); end
    end
  endtask

  task automatic test_one_sample();
    bus.OUT_READY = 1'b1;
    bus.EXPECTED_SAMPLES = 32'd1;
    clear_mon();
    send_pulse(1, 'hFFF);
    repeat (5) @(negedge CLK);
    n_tests += 4;
    if (out_q.size() != 1) begin n_fail++; $display("FAIL one n_entries got %0d want 1", out_q.size()); end
    else if (out_q[0] !== 13'h1FFF) begin n_fail++; $display("FAIL one entry got %h want 1fff", out_q[0]); end
    if (bus.SAMPLE_COUNT !== 32'd1) begin n_fail++; $display("FAIL one SAMPLE_COUNT got %0d want 1", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL one COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    if (pd_cnt != 1) begin n_fail++; $display("FAIL one pd_cnt got %0d want 1", pd_cnt); end
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    bus.EXPECTED_SAMPLES = 32'd200;
    // Ready is forced high when too many samples are outstanding so the FIFO never fills.
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      bus.IN_VALID  = 1'b1;
      bus.IN_DATA   = 12'(i * 37 + 5);
      bus.OUT_READY = ((i + 1 - out_q.size()) > 40) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    guard = 0;
    while (out_q.size() < 200 && guard < 400) begin
      @(posedge CLK); #1;
      bus.OUT_READY = 1'($urandom_range(0, 1));
      guard++;
    end
    bus.OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    n_tests += 5;
    if (out_q.size() != 200) begin n_fail++; $display("FAIL bp n_entries got %0d want 200", out_q.size()); end
    if (bus.OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL bp OVERFLOW got %b want 0", bus.OVERFLOW); end
    if (stall_viol != 0) begin n_fail++; $display("FAIL bp stall_stability got %0d changes want 0", stall_viol); end
    if (bus.SAMPLE_COUNT !== 32'd200) begin n_fail++; $display("FAIL bp SAMPLE_COUNT got %0d want 200", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL bp COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    for (int i = 0; i < 200 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 199), 12'(i * 37 + 5)}) begin
        n_fail++; $display("FAIL bp entry%0d got %h want %h", i, out_q[i], {(i == 199), 12'(i * 37 + 5)});
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    // No reset beforehand: SAMPLE_COUNT holds 200 and the FIFO is busy when RESET drops.
    bus.OUT_READY = 1'b1;
    bus.EXPECTED_SAMPLES = 32'd19;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (i == 31) begin
        RESET = 1'b1;
        clear_mon();
      end
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 12'(16'h100 + i + 1);
      if (i == 30) begin
        RESET = 1'b0;
        #3;
        n_tests += 4;
        if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid OUT_VALID got %b want 0", bus.OUT_VALID); end
        if (bus.OUT_DATA !== 12'h0) begin n_fail++; $display("FAIL rst_mid OUT_DATA got %h want 0", bus.OUT_DATA); end
        if (bus.SAMPLE_COUNT !== 32'd0) begin n_fail++; $display("FAIL rst_mid SAMPLE_COUNT got %0d want 0", bus.SAMPLE_COUNT); end
        if (bus.PULSE_DONE !== 1'b0) begin n_fail++; $display("FAIL rst_mid PULSE_DONE got %b want 0", bus.PULSE_DONE); end
      end
    end
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    n_tests += 4;
    if (out_q.size() != 19) begin n_fail++; $display("FAIL rst_mid n_entries got %0d want 19", out_q.size()); end
    if (bus.SAMPLE_COUNT !== 32'd19) begin n_fail++; $display("FAIL rst_mid SAMPLE_COUNT got %0d want 19", bus.SAMPLE_COUNT); end
    if (bus.COUNT_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_mid COUNT_ERR got %b want 0", bus.COUNT_ERR); end
    if (pd_cnt != 1) begin n_fail++; $display("FAIL rst_mid pd_cnt got %0d want 1", pd_cnt); end
    for (int i = 0; i < 19 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== {(i == 18), 12'(16'h100 + 32 + i)}) begin
        n_fail++; $display("FAIL rst_mid entry%0d got %h want %h", i, out_q[i], {(i == 18), 12'(16'h100 + 32 + i)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_overflow();
    test_one_sample();
    test_backpressure();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
